// File: rtl/mul_pkg.sv
// Shared types and constants for the digit-serial 2x2-core multiplier sequencer.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DIGIT_W     = 2;
    localparam int CORE_PROD_W = 4;

    function automatic int ndig(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/mul_seq_acc.sv
// Shift-and-add accumulator: adds each 4-bit core product at weight 4^(i+j).
module mul_seq_acc
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic [CORE_PROD_W-1:0] cm_i,
    input  logic [CNT_W-1:0]       i_i,
    input  logic [CNT_W-1:0]       j_i,
    output logic [2*WIDTH-1:0]     acc_o,
    output logic [2*WIDTH-1:0]     sum_o
);

    localparam int PW   = 2 * WIDTH;
    localparam int SH_W = $clog2(PW) + 1;

    logic [PW-1:0]   acc_q, acc_d;
    logic [SH_W-1:0] shift;
    logic [PW-1:0]   partial;

    // Digit pair (i,j) carries weight 2^(2(i+j)).
    assign shift   = (SH_W'(i_i) + SH_W'(j_i)) << 1;
    assign partial = PW'(cm_i) << shift;
    assign sum_o   = acc_q + partial;
    assign acc_o   = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer feeding digit pairs to an external 2x2 core and accumulating the product.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    output logic [DIGIT_W-1:0]     CA,
    output logic [DIGIT_W-1:0]     CB,
    input  logic [CORE_PROD_W-1:0] CM,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [2*WIDTH-1:0]     P,
    output state_e                 DBG_STATE
);

    localparam int NDIG  = ndig(WIDTH);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] i_q, i_d, j_q, j_d;
    logic [PW-1:0]    p_q, p_d;
    logic [PW-1:0]    acc_unused;
    logic [PW-1:0]    acc_sum;
    logic             accept;
    logic             last_step;
    logic             running;

    assign running   = (state_q == ST_RUN);
    assign accept    = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_step = running && (i_q == LAST_DIG) && (j_q == LAST_DIG);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: state_d = START ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = running;
        DONE = (state_q == ST_DONE);
        CA   = '0;
        CB   = '0;
        if (running) begin
            CA = DIGIT_W'(a_q >> {i_q, 1'b0});
            CB = DIGIT_W'(b_q >> {j_q, 1'b0});
        end
    end

    // j steps fastest; i advances on j wrap and both return to 0 after the last pair.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        i_d = i_q;
        j_d = j_q;
        p_d = p_q;
        if (accept) begin
            a_d = A;
            b_d = B;
            i_d = '0;
            j_d = '0;
        end else if (running) begin
            if (j_q == LAST_DIG) begin
                j_d = '0;
                i_d = (i_q == LAST_DIG) ? '0 : i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
            if (last_step) begin
                p_d = acc_sum;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= '0;
            b_q <= '0;
            i_q <= '0;
            j_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            i_q <= i_d;
            j_q <= j_d;
            p_q <= p_d;
        end
    end

    mul_seq_acc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  (accept),
        .enable_i (running),
        .cm_i     (CM),
        .i_i      (i_q),
        .j_i      (j_q),
        .acc_o    (acc_unused),
        .sum_o    (acc_sum)
    );

    assign P         = p_q;
    assign DBG_STATE = state_q;

endmodule
